// File: rtl/dual_p_if.sv
// dual_p_if: bus bundle for the DSP output register stage.
//   alu_out        : ALU/post-adder result into the P stage
//   p/pcout/p_fb   : P register output, cascade copy, feedback copy
//   patterndetect  : masked match of PATTERN
//   patternbdetect : masked match of ~PATTERN
//   overflow       : previous cycle matched PATTERN, current matches neither
//   underflow      : previous cycle matched ~PATTERN, current matches neither
// master drives alu_out; slave (the P stage) drives everything else.
interface dual_p_if #(
    parameter int unsigned P_WIDTH = 48
);
    logic [P_WIDTH-1:0] alu_out;
    logic [P_WIDTH-1:0] p;
    logic [P_WIDTH-1:0] pcout;
    logic [P_WIDTH-1:0] p_fb;
    logic               patterndetect;
    logic               patternbdetect;
    logic               overflow;
    logic               underflow;

    modport master (
        output alu_out,
        input  p, pcout, p_fb, patterndetect, patternbdetect, overflow, underflow
    );

    modport slave (
        input  alu_out,
        output p, pcout, p_fb, patterndetect, patternbdetect, overflow, underflow
    );
endinterface

// File: rtl/dual_p.sv
// dual_p: output register stage of the DSP slice datapath.
// Captures the ALU result into P, drives the P feedback and PCOUT cascade,
// and performs masked pattern / pattern-bar detection with overflow and
// underflow flags built from the previous cycle's detect history.
// Ports:
//   clk  : clock
//   rstp : synchronous active-high reset of P, detect and history registers
//   cep  : clock enable for every register in this block
//   bus  : dual_p_if slave (alu_out in; p, pcout, p_fb, flags out)
// Optional feature macro: AUTORESET_PATDET_EN (PREG=1 only) clears P and the
// detect registers on the edge after a registered pattern match.
module dual_p #(
    parameter int unsigned        P_WIDTH            = 48,
    parameter int unsigned        PREG               = 1,
    parameter logic [P_WIDTH-1:0] PATTERN            = '0,
    parameter logic [P_WIDTH-1:0] MASK               = P_WIDTH'(48'h3FFF_FFFF_FFFF),
    parameter string              USE_PATTERN_DETECT = "PATDET"
) (
    input  logic     clk,
    input  logic     rstp,
    input  logic     cep,
    dual_p_if.slave  bus
);

    localparam bit DET_EN = (USE_PATTERN_DETECT == "PATDET");

    logic               pd_c;
    logic               pbd_c;
    logic [P_WIDTH-1:0] p_sel;
    logic               pd_sel;
    logic               pbd_sel;
    logic               pd_past;
    logic               pbd_past;

    // Masked compare of the live ALU result against PATTERN and ~PATTERN.
    assign pd_c  = ((bus.alu_out ^ PATTERN)  & ~MASK) == '0;
    assign pbd_c = ((bus.alu_out ^ ~PATTERN) & ~MASK) == '0;

    generate
        if (PREG == 1) begin : g_preg
            logic [P_WIDTH-1:0] p_q;
            logic               pd_q;
            logic               pbd_q;

            // P and detect registers; autoreset (when built) sits between
            // reset and normal load in priority.
            always_ff @(posedge clk) begin
                if (rstp) begin
                    p_q   <= '0;
                    pd_q  <= 1'b0;
                    pbd_q <= 1'b0;
                end
`ifdef AUTORESET_PATDET_EN
                else if (cep && pd_q) begin
                    p_q   <= '0;
                    pd_q  <= 1'b0;
                    pbd_q <= 1'b0;
                end
`endif
                else if (cep) begin
                    p_q   <= bus.alu_out;
                    pd_q  <= pd_c;
                    pbd_q <= pbd_c;
                end
            end

            assign p_sel   = p_q;
            assign pd_sel  = pd_q;
            assign pbd_sel = pbd_q;
        end else begin : g_comb
            assign p_sel   = bus.alu_out;
            assign pd_sel  = pd_c;
            assign pbd_sel = pbd_c;
        end
    endgenerate

    // Detect history. During an autoreset the pre-clear pd (1) and pbd are
    // exactly what pd_sel/pbd_sel hold, so one load path covers both cases.
    always_ff @(posedge clk) begin
        if (rstp) begin
            pd_past  <= 1'b0;
            pbd_past <= 1'b0;
        end else if (cep) begin
            pd_past  <= pd_sel;
            pbd_past <= pbd_sel;
        end
    end

    assign bus.p              = p_sel;
    assign bus.pcout          = p_sel;
    assign bus.p_fb           = p_sel;
    assign bus.patterndetect  = DET_EN & pd_sel;
    assign bus.patternbdetect = DET_EN & pbd_sel;
    // Left the matched region: was a match last cycle, neither match now.
    assign bus.overflow       = DET_EN & pd_past  & ~pd_sel & ~pbd_sel;
    assign bus.underflow      = DET_EN & pbd_past & ~pd_sel & ~pbd_sel;

endmodule

// File: tb/tb_dual_p.sv
// tb_dual_p: directed bench for dual_p. Three instances share the stimulus:
// registered (PREG=1), pass-through (PREG=0) and fully masked (MASK all ones).
module tb_dual_p;

    localparam int unsigned W = 48;
`ifdef AUTORESET_PATDET_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk;
    logic         rstp;
    logic         cep;
    logic [W-1:0] alu;
    int           checks;
    int           errors;

    dual_p_if #(.P_WIDTH(W)) bus_r ();
    dual_p_if #(.P_WIDTH(W)) bus_c ();
    dual_p_if #(.P_WIDTH(W)) bus_m ();

    assign bus_r.alu_out = alu;
    assign bus_c.alu_out = alu;
    assign bus_m.alu_out = alu;

    dual_p #(.P_WIDTH(W), .PREG(1)) u_reg (
        .clk  (clk),
        .rstp (rstp),
        .cep  (cep),
        .bus  (bus_r)
    );

    dual_p #(.P_WIDTH(W), .PREG(0)) u_comb (
        .clk  (clk),
        .rstp (rstp),
        .cep  (cep),
        .bus  (bus_c)
    );

    dual_p #(.P_WIDTH(W), .PREG(1), .MASK({W{1'b1}})) u_mask (
        .clk  (clk),
        .rstp (rstp),
        .cep  (cep),
        .bus  (bus_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags_r(input string tag, input logic pd, input logic pbd,
                           input logic ov, input logic un);
        check_b({tag, " pd"},  bus_r.patterndetect,  pd);
        check_b({tag, " pbd"}, bus_r.patternbdetect, pbd);
        check_b({tag, " ovf"}, bus_r.overflow,       ov);
        check_b({tag, " unf"}, bus_r.underflow,      un);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with a live input.
        rstp = 1'b1; cep = 1'b1; alu = 48'h123;
        step();
        check_v("rst p", bus_r.p, 48'h0);
        flags_r("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_v("rst comb p", bus_c.p, 48'h123);
        check_b("rst comb pd", bus_c.patterndetect, 1'b1);
        check_b("rst comb ovf", bus_c.overflow, 1'b0);

        // Release: one-cycle latency.
        rstp = 1'b0;
        step();
        check_v("rel p", bus_r.p, 48'h123);
        check_v("rel pcout", bus_r.pcout, 48'h123);
        check_v("rel p_fb", bus_r.p_fb, 48'h123);
        flags_r("rel", 1'b1, 1'b0, 1'b0, 1'b0);
        check_b("mask pd", bus_m.patterndetect, 1'b1);
        check_b("mask pbd", bus_m.patternbdetect, 1'b1);

        // Hold with cep=0.
        rstp = 1'b1; step(); rstp = 1'b0;
        alu = 48'h0000_0000_1234;
        step();
        check_v("load p", bus_r.p, 48'h1234);
        cep = 1'b0; alu = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_v("hold p", bus_r.p, 48'h1234);
            flags_r("hold", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_v("hold comb p", bus_c.p, 48'hFFFF_FFFF_FFFF);
        check_b("hold comb pbd", bus_c.patternbdetect, 1'b1);
        check_b("hold comb unf", bus_c.underflow, 1'b0);
        // Frozen comb history (pd_past=1 from the 0x1234 edge) exposed by a neither-value.
        alu = 48'h4000_0000_0000;
        #1;
        check_b("hold comb ovf", bus_c.overflow, 1'b1);
        step();
        check_b("hold comb ovf2", bus_c.overflow, 1'b1);
        cep = 1'b1;

        // Overflow.
        rstp = 1'b1; step(); rstp = 1'b0;
        alu = 48'h3FFF_FFFF_FFFF;
        step();
        flags_r("ovf a", 1'b1, 1'b0, 1'b0, 1'b0);
        alu = 48'h4000_0000_0000;
        #1;
        check_b("comb ovf live", bus_c.overflow, 1'b1);
        check_b("comb pd live", bus_c.patterndetect, 1'b0);
        step();
        flags_r("ovf b", 1'b0, 1'b0, 1'b1, 1'b0);
        check_b("comb ovf after", bus_c.overflow, 1'b0);
        alu = 48'h4000_0000_0001;
        step();
        check_v("ovf c p", bus_r.p, 48'h4000_0000_0001);
        flags_r("ovf c", 1'b0, 1'b0, 1'b0, 1'b0);

        // Underflow.
        rstp = 1'b1; step(); rstp = 1'b0;
        alu = 48'hC000_0000_0000;
        step();
        flags_r("unf a", 1'b0, 1'b1, 1'b0, 1'b0);
        alu = 48'hBFFF_FFFF_FFFF;
        step();
        flags_r("unf b", 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-stream reset clears history.
        alu = 48'hC000_0000_0000;
        step();
        check_b("mid pbd", bus_r.patternbdetect, 1'b1);
        rstp = 1'b1;
        step();
        flags_r("mid rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rstp = 1'b0; alu = 48'hBFFF_FFFF_FFFF;
        step();
        flags_r("mid rel", 1'b0, 1'b0, 1'b0, 1'b0);

        // Autoreset after a match (plain reload without the feature).
        rstp = 1'b1; step(); rstp = 1'b0;
        alu = 48'h5;
        step();
        check_v("ar a p", bus_r.p, 48'h5);
        check_b("ar a pd", bus_r.patterndetect, 1'b1);
        alu = 48'h7;
        step();
        check_v("ar b p", bus_r.p, AR ? 48'h0 : 48'h7);
        check_b("ar b pd", bus_r.patterndetect, !AR);
        step();
        check_v("ar c p", bus_r.p, 48'h7);

        // Fully masked instance never flags over/underflow.
        check_b("mask ovf", bus_m.overflow, 1'b0);
        check_b("mask unf", bus_m.underflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
